sram_access_ctrl: RTL and testbench

//   Clocked, parametrised controller for an asynchronous SRAM with active-low CE/WE/OE and shared DQ.

---
 rtl/sram_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Request/ready front end for an asynchronous SRAM with active-low CE/WE/OE and a shared DQ bus.
// Sequences registered strobes for reads and writes and returns read data with a one-cycle rvalid pulse.
module sram_access_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned WE_PULSE = 2,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic              clk_i,
    input  logic              clr_ni,
    input  logic              req_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              wdone_o,
    output logic [ADDR_W-1:0] a_o,
    inout  wire  [DATA_W-1:0] dq_io,
    output logic              ce_o,
    output logic              we_o,
    output logic              oe_o
);

    localparam int unsigned MaxAb  = (RD_WAIT > WE_PULSE) ? RD_WAIT : WE_PULSE;
    localparam int unsigned MaxCyc = (MaxAb > TURN_CYC) ? MaxAb : TURN_CYC;
    localparam int unsigned CntW   = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StTurn,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              wdone_q, wdone_d;
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic              dq_en_q, dq_en_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    a_d     = addr_i;
                    wdata_d = wdata_i;
                    if (rw_i) begin
                        state_d = StWrSetup;
                        cnt_d   = '0;
                    end else begin
                        state_d = StRd;
                        cnt_d   = CntW'(RD_WAIT - 1);
                    end
                end
            end
            StRd: begin
                if (cnt_q == '0) begin
                    rdata_d  = dq_io;
                    rvalid_d = 1'b1;
                    if (TURN_CYC == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StTurn;
                        cnt_d   = CntW'(TURN_CYC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
                cnt_d   = CntW'(WE_PULSE - 1);
            end
            StWrPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: begin
                state_d = StIdle;
                wdone_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with state_q.
    always_comb begin
        ce_d    = !(state_d inside {StRd, StWrSetup, StWrPulse, StWrHold});
        oe_d    = (state_d != StRd);
        we_d    = (state_d != StWrPulse);
        dq_en_d = (state_d inside {StWrSetup, StWrPulse, StWrHold});
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            ce_q     <= 1'b1;
            we_q     <= 1'b1;
            oe_q     <= 1'b1;
            dq_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            dq_en_q  <= dq_en_d;
        end
    end

    assign dq_io    = dq_en_q ? wdata_q : {DATA_W{1'bz}};
    assign ready_o  = (state_q == StIdle);
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign wdone_o  = wdone_q;
    assign a_o      = a_q;
    assign ce_o     = ce_q;
    assign we_o     = we_q;
    assign oe_o     = oe_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM device, scoreboard memory and per-cycle
// expectations derived from the documented access timelines.
module tb_sram_access_ctrl;

    localparam int unsigned RdWait  = 2;
    localparam int unsigned WePulse = 2;
    localparam int unsigned TurnCyc = 1;

    logic       clk;
    logic       clr_n;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    wire        ready;
    wire  [7:0] rdata;
    wire        rvalid;
    wire        wdone;
    wire  [7:0] a;
    wire  [7:0] dq;
    wire        ce;
    wire        we;
    wire        oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] sram    [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] last_rd;

    sram_access_ctrl #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .RD_WAIT (RdWait),
        .WE_PULSE(WePulse),
        .TURN_CYC(TurnCyc)
    ) dut (
        .clk_i   (clk),
        .clr_ni  (clr_n),
        .req_i   (req),
        .rw_i    (rw),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ready_o (ready),
        .rdata_o (rdata),
        .rvalid_o(rvalid),
        .wdone_o (wdone),
        .a_o     (a),
        .dq_io   (dq),
        .ce_o    (ce),
        .we_o    (we),
        .oe_o    (oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous SRAM: drives DQ on a read cycle, absorbs DQ while WE is low.
    assign dq = (!ce && !oe && we) ? sram[a] : 8'hzz;

    always @(negedge clk) begin
        if (clr_n && !ce && !we) sram[a] <= dq;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n === 1'b1 && oe === 1'b0) check_eq("oe_only_in_read", 32'({ce, we}), 32'(2'b01));
    end

    // {ce, oe, we, rvalid, wdone, ready}
    task automatic check_idle(input string tag);
        check_eq(tag, 32'({ce, oe, we, rvalid, wdone, ready}), 32'(6'b111001));
        check_eq({tag, "_rdata"}, 32'(rdata), 32'(last_rd));
    endtask

    // Called at a negedge. mode 0: drop req while busy, 1: hold req high, 2: random req noise.
    task automatic do_txn(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_data,
                          input int mode);
        int n_end;
        int waited;
        logic e_ce, e_oe, e_we, e_rv, e_wd, e_rdy;
        req   = 1'b1;
        rw    = t_rw;
        addr  = t_addr;
        wdata = t_data;
        waited = 0;
        while (ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            check_eq("accept_timeout", 32'(waited), 32'(0));
            req = 1'b0;
            return;
        end
        n_end = t_rw ? WePulse + 2 : RdWait + TurnCyc;
        for (int k = 0; k <= n_end; k++) begin
            @(negedge clk);
            e_rdy = (k >= n_end);
            e_rv  = 1'b0;
            e_wd  = 1'b0;
            if (!t_rw) begin
                e_ce = (k >= RdWait);
                e_oe = (k >= RdWait);
                e_we = 1'b1;
                e_rv = (k == RdWait);
                if (k == RdWait) last_rd = ref_mem[t_addr];
                if (k >= RdWait) check_eq("rd_data", 32'(rdata), 32'(last_rd));
                if (k < RdWait) check_eq("rd_addr", 32'(a), 32'(t_addr));
            end else begin
                e_ce = (k == n_end);
                e_oe = 1'b1;
                e_we = !(k >= 1 && k <= WePulse);
                e_wd = (k == n_end);
                if (k == n_end) begin
                    ref_mem[t_addr] = t_data;
                end else begin
                    check_eq("wr_addr", 32'(a), 32'(t_addr));
                    check_eq("wr_dq", 32'(dq), 32'(t_data));
                end
                check_eq("wr_rdata_hold", 32'(rdata), 32'(last_rd));
            end
            check_eq(t_rw ? "wr_strobes" : "rd_strobes", 32'({ce, oe, we, rvalid, wdone, ready}),
                     32'({e_ce, e_oe, e_we, e_rv, e_wd, e_rdy}));
            if (k < n_end) begin
                if (mode == 0) begin
                    req = 1'b0;
                end else if (mode == 2) begin
                    req = 1'($urandom_range(0, 1));
                end
                if (mode != 1) begin
                    rw    = 1'($urandom);
                    addr  = 8'($urandom);
                    wdata = 8'($urandom);
                end
            end else begin
                req = 1'b0;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        last_rd = 8'h00;
        clr_n = 1'b0;
        req   = 1'b0;
        rw    = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;

        repeat (3) @(negedge clk);
        check_idle("reset_idle");
        check_eq("reset_addr", 32'(a), 32'(0));
        clr_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset_idle");

        do_txn(1'b1, 8'h12, 8'h5A, 0);
        do_txn(1'b0, 8'h12, 8'h00, 0);
        check_eq("readback_5a", 32'(rdata), 32'(8'h5A));

        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 8'(i), 8'($urandom), 1);
            do_txn(1'b0, 8'(i), 8'h00, 1);
        end

        for (int i = 0; i < 30; i++) begin
            do_txn(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 2);
        end

        repeat (3) begin
            @(negedge clk);
            check_idle("quiet_idle");
        end

        // Abort a write while WE is low; SRAM has already absorbed the data.
        req   = 1'b1;
        rw    = 1'b1;
        addr  = 8'h40;
        wdata = 8'hC3;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_we_low", 32'(we), 32'(0));
        ref_mem[8'h40] = 8'hC3;
        #1 clr_n = 1'b0;
        #1;
        check_eq("abort_strobes", 32'({ce, oe, we, rvalid, wdone, ready}), 32'(6'b111001));
        check_eq("abort_addr", 32'(a), 32'(0));
        check_eq("abort_rdata", 32'(rdata), 32'(0));
        last_rd = 8'h00;
        @(negedge clk);
        check_idle("abort_held");
        clr_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("abort_no_wdone");
        end

        do_txn(1'b1, 8'h20, 8'h96, 0);
        do_txn(1'b0, 8'h20, 8'h00, 0);
        check_eq("post_abort_read", 32'(rdata), 32'(8'h96));
        do_txn(1'b0, 8'h40, 8'h00, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
